text_fetch_arbiter: RTL and testbench

Sequences the shared single-port text RAM between the video scan-out and a CPU port. Sits between `vgaController` (x/y) and the character generator: it prefetches each cell's character code so it is stable for that cell's 8 pixels, and grants CPU read/write accesses in every RAM cycle the video pipeline does not need.

---
 rtl/text_fetch_arbiter.sv | 148 ++++++++++++++
 tb/tb_text_fetch_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_fetch_arbiter.sv
// Shares a single-port text RAM between video prefetch (addr at x%8==5, ch at cell boundary) and a CPU port.
// Video wins every slot; a CPU access completes 2-3 cycles after req. Define VBLANK_ONLY_EN to restrict CPU grants to vertical blank.
module text_fetch_arbiter #(
    parameter int HACTIVE = 640,
    parameter int HMAX    = 800,
    parameter int VACTIVE = 480,
    parameter int VMAX    = 525,
    parameter int COLS    = 80,
    parameter int ADDR_W  = 13
) (
    input  logic              vgaclk,
    input  logic              reset_b,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        ch,
    output logic              ch_valid
);

    localparam int HCELLS = HMAX / 8;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACK} state_t;

    state_t            r_state;
    logic              r_run;
    logic              r_acc_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_vid_pend;
    logic [7:0]        r_stage;
    logic              r_stage_vld;
    logic [7:0]        r_ch;
    logic              r_ch_vld;
    logic [7:0]        r_rdata;

    logic [7:0]        w_col_nxt;
    logic [7:0]        w_tcol;
    logic [9:0]        w_tline;
    logic              w_tgt_ok;
    logic              w_vid_now;
    logic              w_vid_next;
    logic              w_cpu_window;
    logic [31:0]       w_vaddr_full;
    logic [ADDR_W-1:0] w_vaddr;

    // Target of the fetch made in this cell: next column, wrapping to the next line / frame.
    always_comb begin
        w_col_nxt = {1'b0, x[9:3]} + 8'd1;
        w_tcol    = w_col_nxt;
        w_tline   = y;
        if (32'(w_col_nxt) == HCELLS) begin
            w_tcol  = 8'd0;
            w_tline = (32'(y) == VMAX - 1) ? 10'd0 : y + 10'd1;
        end
    end

    assign w_tgt_ok = (32'(w_tcol) < COLS) && (32'({w_tcol, 3'b000}) < HACTIVE)
                   && (32'(w_tline) < VACTIVE);
    assign w_vid_now    = r_run && w_tgt_ok && (x[2:0] == 3'd5);
    // The target column is unchanged between x%8==4 and 5, so the next slot is predictable.
    assign w_vid_next   = w_tgt_ok && (x[2:0] == 3'd4);
    assign w_vaddr_full = 32'(w_tline[9:3]) * COLS + 32'(w_tcol);
    assign w_vaddr      = w_vaddr_full[ADDR_W-1:0];

`ifdef VBLANK_ONLY_EN
    assign w_cpu_window = (32'(y) >= VACTIVE);
`else
    assign w_cpu_window = 1'b1;
`endif

    always_comb begin
        ram_addr  = r_ram_addr;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        if (w_vid_now) begin
            ram_addr = w_vaddr;
        end else if (r_state == S_GRANT) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    assign cpu_ack   = (r_state == S_ACK);
    assign cpu_rdata = (r_state == S_ACK && !r_acc_we) ? ram_rdata : r_rdata;
    assign ch        = r_ch;
    assign ch_valid  = r_ch_vld;

    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            r_state     <= S_IDLE;
            r_run       <= 1'b0;
            r_acc_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_vid_pend  <= 1'b0;
            r_stage     <= 8'd0;
            r_stage_vld <= 1'b0;
            r_ch        <= 8'd0;
            r_ch_vld    <= 1'b0;
            r_rdata     <= 8'd0;
        end else begin
            r_run      <= 1'b1;
            r_ram_addr <= ram_addr;
            r_vid_pend <= w_vid_now;

            case (r_state)
                S_IDLE: begin
                    if (cpu_req && w_cpu_window && !w_vid_next) begin
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_acc_we <= cpu_we;
                    r_state  <= S_ACK;
                end
                S_ACK: begin
                    if (!r_acc_we) begin
                        r_rdata <= ram_rdata;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (x[2:0] == 3'd5 && !w_vid_now) begin
                r_stage     <= 8'd0;
                r_stage_vld <= 1'b0;
            end
            if (x[2:0] == 3'd6 && r_vid_pend) begin
                r_stage     <= ram_rdata;
                r_stage_vld <= 1'b1;
            end
            if (x[2:0] == 3'd7) begin
                r_ch     <= r_stage;
                r_ch_vld <= r_stage_vld;
            end
        end
    end

endmodule

// File: tb/tb_text_fetch_arbiter.sv
// Directed bench for text_fetch_arbiter: drives x/y directly (jumping between regions of interest) with a behavioural sync-read RAM.
module tb_text_fetch_arbiter;

    logic        vgaclk = 1'b0;
    logic        reset_b;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  ch;
    logic        ch_valid;

    logic [7:0]  mem [0:8191];
    int          n_checks = 0;
    int          n_pass   = 0;

    text_fetch_arbiter dut (
        .vgaclk    (vgaclk),
        .reset_b   (reset_b),
        .x         (x),
        .y         (y),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ch        (ch),
        .ch_valid  (ch_valid)
    );

    always #5 vgaclk = ~vgaclk;

    always @(posedge vgaclk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // One pixel clock: inputs advance 1ns after the edge, outputs are sampled 2ns after.
    task automatic tick();
        @(posedge vgaclk);
        #1;
        if (x == 10'd799) begin
            x = 10'd0;
            y = (y == 10'd524) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        int we_seen;
        x = 10'd0; y = 10'd0;
        ticks(5);
        n_checks++; if (ch !== 8'd0) $display("FAIL reset_ch got %h want 00", ch); else n_pass++;
        n_checks++; if (ch_valid !== 1'b0) $display("FAIL reset_ch_valid got %b want 0", ch_valid); else n_pass++;
        n_checks++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack got %b want 0", cpu_ack); else n_pass++;
        n_checks++; if (cpu_rdata !== 8'd0) $display("FAIL reset_cpu_rdata got %h want 00", cpu_rdata); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got %b want 0", ram_we); else n_pass++;
        n_checks++; if (ram_addr !== 13'd0) $display("FAIL reset_ram_addr got %h want 0000", ram_addr); else n_pass++;
        reset_b = 1'b1;
        we_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ram_we !== 1'b0) we_seen++;
        end
        n_checks++; if (we_seen != 0) $display("FAIL idle_ram_we got %0d cycles want 0", we_seen); else n_pass++;
    endtask

    task automatic test_scanout();
        int bad;
        x = 10'd0; y = 10'd8;
        ticks(8);
        n_checks++; if (ch !== 8'h51 || ch_valid !== 1'b1) $display("FAIL scan_x8 got %h/%b want 51/1", ch, ch_valid); else n_pass++;
        ticks(8);
        n_checks++; if (ch !== 8'h52) $display("FAIL scan_x16_ch got %h want 52", ch); else n_pass++;
        n_checks++; if (ch_valid !== 1'b1) $display("FAIL scan_x16_valid got %b want 1", ch_valid); else n_pass++;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (ch !== 8'h52) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL scan_hold got %0d changes want 0", bad); else n_pass++;
        x = 10'd624;
        ticks(8);
        n_checks++; if (ch !== 8'h9F || ch_valid !== 1'b1) $display("FAIL scan_col79 got %h/%b want 9f/1", ch, ch_valid); else n_pass++;
        bad = 0;
        while (x != 10'd799) begin
            tick();
            if (x >= 10'd640 && (ch_valid !== 1'b0 || ch !== 8'd0)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL scan_hblank got %0d bad cycles want 0", bad); else n_pass++;
        tick();
        n_checks++; if (ch !== 8'h50 || ch_valid !== 1'b1) $display("FAIL scan_next_line got %h/%b want 50/1", ch, ch_valid); else n_pass++;
    endtask

    task automatic test_frame_wrap();
        x = 10'd792; y = 10'd524;
        ticks(4);
        n_checks++; if (ram_addr !== 13'd80) $display("FAIL wrap_hold got %0d want 80", ram_addr); else n_pass++;
        tick();
        n_checks++; if (ram_addr !== 13'd0 || ram_we !== 1'b0) $display("FAIL wrap_addr got %0d/%b want 0/0", ram_addr, ram_we); else n_pass++;
        ticks(3);
        n_checks++; if (x !== 10'd0 || y !== 10'd0 || ch !== 8'hC3 || ch_valid !== 1'b1)
            $display("FAIL wrap_ch got %h/%b at %0d,%0d want c3/1 at 0,0", ch, ch_valid, x, y); else n_pass++;
    endtask

    task automatic test_cpu_write_collision();
        x = 10'd8; y = 10'd8;
        ticks(5);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 8'hA5;
        #1;
        n_checks++; if (ram_addr !== 13'd82 || ram_we !== 1'b0) $display("FAIL coll_slot got %0d/%b want 82/0", ram_addr, ram_we); else n_pass++;
        tick();
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 13'd5 || ram_wdata !== 8'hA5 || cpu_ack !== 1'b0)
            $display("FAIL coll_grant got we%b a%0d d%h ack%b want 1/5/a5/0", ram_we, ram_addr, ram_wdata, cpu_ack); else n_pass++;
        tick();
        n_checks++; if (cpu_ack !== 1'b1 || ram_we !== 1'b0) $display("FAIL coll_ack got %b/%b want 1/0", cpu_ack, ram_we); else n_pass++;
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        n_checks++; if (ch !== 8'h52 || ch_valid !== 1'b1 || cpu_ack !== 1'b0)
            $display("FAIL coll_video got %h/%b ack%b want 52/1/0", ch, ch_valid, cpu_ack); else n_pass++;
        n_checks++; if (mem[5] !== 8'hA5) $display("FAIL coll_mem got %h want a5", mem[5]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first, last, acks, min_gap, bad_rd;
        first = -1; last = -1; acks = 0; min_gap = 1000; bad_rd = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (cpu_ack === 1'b1) begin
                acks++;
                if (first < 0) first = i;
                if (last >= 0 && i - last < min_gap) min_gap = i - last;
                last = i;
                if (cpu_rdata !== 8'hA5) bad_rd++;
            end
        end
        cpu_req = 1'b0;
        n_checks++; if (first != 2) $display("FAIL b2b_first got %0d want 2", first); else n_pass++;
        n_checks++; if (bad_rd != 0) $display("FAIL b2b_rdata got %0d bad want 0", bad_rd); else n_pass++;
        n_checks++; if (acks != 3) $display("FAIL b2b_count got %0d want 3", acks); else n_pass++;
        n_checks++; if (min_gap != 3) $display("FAIL b2b_gap got %0d want 3", min_gap); else n_pass++;
        tick();
    endtask

    task automatic test_vblank_window();
        int got;
        got = -1;
        x = 10'd0; y = 10'd100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
`ifdef VBLANK_ONLY_EN
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cpu_ack === 1'b1 && got < 0) got = i;
        end
        n_checks++; if (got >= 0) $display("FAIL vb_active_ack got ack at %0d want none", got); else n_pass++;
        x = 10'd0; y = 10'd480;
        got = -1;
`endif
        for (int i = 1; i <= 3 && got < 0; i++) begin
            tick();
            if (cpu_ack === 1'b1) got = i;
        end
        n_checks++; if (got < 0 || cpu_rdata !== 8'hA5) $display("FAIL vb_ack got lat %0d data %h want <=3/a5", got, cpu_rdata); else n_pass++;
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_midaccess();
        int bad;
        x = 10'd16; y = 10'd8;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0006; cpu_wdata = 8'h5A;
        tick();
        n_checks++; if (ram_we !== 1'b1) $display("FAIL mid_grant got %b want 1", ram_we); else n_pass++;
        reset_b = 1'b0;
        #1;
        n_checks++; if (ram_we !== 1'b0 || cpu_ack !== 1'b0 || ram_addr !== 13'd0)
            $display("FAIL mid_reset got we%b ack%b a%0d want 0/0/0", ram_we, cpu_ack, ram_addr); else n_pass++;
        cpu_req = 1'b0; cpu_we = 1'b0;
        ticks(2);
        reset_b = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_ack !== 1'b0 || ram_we !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL mid_after got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++; if (mem[6] !== 8'h06) $display("FAIL mid_mem got %h want 06", mem[6]); else n_pass++;
    endtask

    initial begin
        reset_b = 1'b1;
        x = 10'd0; y = 10'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 13'd0; cpu_wdata = 8'd0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i);
        mem[0] = 8'hC3;
        #2 reset_b = 1'b0;
        test_reset();
        test_scanout();
        test_frame_wrap();
        test_cpu_write_collision();
        test_back_to_back();
        test_vblank_window();
        test_reset_midaccess();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
